// File: rtl/fx_match_share_ctrl_if.sv
// Requester, datapath and response bundle for the
// shared fixed-point format-match scheduler.
interface fx_match_share_ctrl_if #(
  parameter int N_REQ = 4,
  parameter int DW    = 15
);
  logic [N_REQ-1:0]    i_req_valid;
  logic [N_REQ*DW-1:0] i_req_data;
  logic [N_REQ-1:0]    o_req_ready;
  logic [DW-1:0]       o_fx_data;
  logic                o_fx_valid;
  logic [DW-1:0]       i_fx_data;
  logic [N_REQ-1:0]    o_rsp_valid;
  logic [DW-1:0]       o_rsp_data;

  modport slave (
    input  i_req_valid,
    input  i_req_data,
    input  i_fx_data,
    output o_req_ready,
    output o_fx_data,
    output o_fx_valid,
    output o_rsp_valid,
    output o_rsp_data
  );

  modport master (
    output i_req_valid,
    output i_req_data,
    output i_fx_data,
    input  o_req_ready,
    input  o_fx_data,
    input  o_fx_valid,
    input  o_rsp_valid,
    input  o_rsp_data
  );
endinterface

// File: rtl/fx_match_share_ctrl.sv
// Round-robin time-sharing of one format-match unit among
// N_REQ requesters, with tag tracking back to the owner.
module fx_match_share_ctrl #(
  parameter int N_REQ = 4,
  parameter int DW    = 15,
  parameter int LAT   = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_en,
  fx_match_share_ctrl_if.slave      bus,
  output logic                      o_busy,
  output logic [$clog2(LAT+2)-1:0]  o_inflight
);
  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = $clog2(LAT + 2);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

  typedef struct packed {
    logic          v;
    logic [IW-1:0] idx;
  } tag_t;

  state_t        state;
  state_t        state_nx;
  logic [IW-1:0] ptr;
  logic [IW-1:0] win;
  logic          any;
  logic          xfer;
  int unsigned   pos;
  logic [DW-1:0] fx_data;
  logic [CW-1:0] inflight;

  // tag[0] rides with o_fx_data; tag[LAT] meets i_fx_data
  tag_t tag [LAT+1];

  always_comb begin
    win = ptr;
    any = 1'b0;
    pos = 0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      pos = int'(ptr) + i;
      if (pos >= N_REQ) pos = pos - N_REQ;
      if (bus.i_req_valid[pos]) begin
        win = IW'(pos);
        any = 1'b1;
      end
    end
  end

  assign xfer = (state == RUN) && any;

  assign bus.o_req_ready = xfer ? (N_REQ'(1) << win) : '0;

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (i_en) state_nx = RUN;
      end
      RUN: begin
        if (!i_en) state_nx = DRAIN;
      end
      DRAIN: begin
        if (i_en)
          state_nx = RUN;
        else if (inflight == '0 && !tag[0].v)
          state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ptr   <= '0;
    end else begin
      state <= state_nx;
      if (xfer)
        ptr <= (win == IW'(N_REQ - 1)) ? '0 : win + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fx_data <= '0;
      for (int s = 0; s <= LAT; s++) tag[s] <= '0;
    end else begin
      if (xfer) fx_data <= bus.i_req_data[win*DW +: DW];
      tag[0].v   <= xfer;
      tag[0].idx <= win;
      for (int s = 1; s <= LAT; s++) tag[s] <= tag[s-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight <= '0;
    end else begin
      unique case ({xfer, tag[LAT].v})
        2'b10:   inflight <= inflight + 1'b1;
        2'b01:   inflight <= inflight - 1'b1;
        default: inflight <= inflight;
      endcase
    end
  end

  assign bus.o_fx_data  = fx_data;
  assign bus.o_fx_valid = tag[0].v;

  assign bus.o_rsp_valid = tag[LAT].v ?
    (N_REQ'(1) << tag[LAT].idx) : '0;
  assign bus.o_rsp_data  = bus.i_fx_data;

  assign o_busy     = (state != IDLE);
  assign o_inflight = inflight;
endmodule

// File: tb/tb_fx_match_share_ctrl.sv
// Directed bench for fx_match_share_ctrl: expected responses
// are queued at grant time and popped by a response monitor.
module tb_fx_match_share_ctrl;
  localparam int N_REQ = 4;
  localparam int DW    = 15;
  localparam int LAT   = 2;
  localparam int CW    = $clog2(LAT + 2);

  typedef struct packed {
    logic [N_REQ-1:0] own;
    logic [DW-1:0]    data;
  } rsp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic          busy;
  logic [CW-1:0] inflight;

  int   checks = 0;
  int   errors = 0;
  int   seq = 0;
  rsp_t exp_q [$];
  rsp_t mon_e;

  fx_match_share_ctrl_if #(.N_REQ(N_REQ), .DW(DW)) bus ();

  fx_match_share_ctrl #(
    .N_REQ (N_REQ),
    .DW    (DW),
    .LAT   (LAT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_en       (en),
    .bus        (bus.slave),
    .o_busy     (busy),
    .o_inflight (inflight)
  );

  always #5 clk = ~clk;

  // stand-in for the shared format-match unit
  function automatic logic [DW-1:0] fx_model(input logic [DW-1:0] x);
    return {x[DW-2:0], x[DW-1]} ^ DW'(15'h2a5a);
  endfunction

  logic [DW-1:0] dl [LAT];
  always @(posedge clk) begin
    dl[0] <= bus.o_fx_data;
    for (int s = 1; s < LAT; s++) dl[s] <= dl[s-1];
  end
  assign bus.i_fx_data = fx_model(dl[LAT-1]);

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus.o_rsp_valid != '0) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rsp_unexpected: got owner %b data %h, required none",
                 bus.o_rsp_valid, bus.o_rsp_data);
      end else begin
        mon_e = exp_q.pop_front();
        if (bus.o_rsp_valid !== mon_e.own ||
            bus.o_rsp_data !== mon_e.data) begin
          errors++;
          $display("FAIL rsp: got owner %b data %h, required owner %b data %h",
                   bus.o_rsp_valid, bus.o_rsp_data, mon_e.own, mon_e.data);
        end
      end
    end
  end

  task automatic step(input logic e, input logic [N_REQ-1:0] v,
                      input logic [N_REQ-1:0] exp_rdy,
                      input int exp_inf, input int exp_busy);
    logic [DW-1:0] d [N_REQ];
    rsp_t r;
    en = e;
    bus.i_req_valid = v;
    for (int k = 0; k < N_REQ; k++) begin
      d[k] = DW'((k << 11) | (seq & 'h7ff));
      bus.i_req_data[k*DW +: DW] = d[k];
    end
    seq++;
    @(negedge clk);
    chk("ready", 32'(bus.o_req_ready), 32'(exp_rdy));
    if (exp_inf >= 0) chk("inflight", 32'(inflight), exp_inf);
    if (exp_busy >= 0) chk("busy", 32'(busy), exp_busy);
    for (int k = 0; k < N_REQ; k++) begin
      if (exp_rdy[k] && v[k]) begin
        r.own  = exp_rdy;
        r.data = fx_model(d[k]);
        exp_q.push_back(r);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ready"}, 32'(bus.o_req_ready), 0);
    chk({tag, "_fx_valid"}, 32'(bus.o_fx_valid), 0);
    chk({tag, "_fx_data"}, 32'(bus.o_fx_data), 0);
    chk({tag, "_rsp_valid"}, 32'(bus.o_rsp_valid), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_inflight"}, 32'(inflight), 0);
  endtask

  initial begin
    bus.i_req_valid = '0;
    bus.i_req_data  = '0;
    repeat (2) @(negedge clk);
    chk_zero("reset");
    @(posedge clk);
    #1 rst_n = 1'b1;

    step(1, 4'b0000, 4'b0000, 0, 0);
    // all four valid: strict rotation
    step(1, 4'b1111, 4'b0001, 0, 1);
    step(1, 4'b1111, 4'b0010, 1, -1);
    step(1, 4'b1111, 4'b0100, 2, -1);
    step(1, 4'b1111, 4'b1000, 3, -1);
    step(1, 4'b1111, 4'b0001, 3, -1);
    step(1, 4'b1111, 4'b0010, -1, -1);
    step(1, 4'b1111, 4'b0100, -1, -1);
    step(1, 4'b1111, 4'b1000, -1, -1);
    // lone requester 2
    step(1, 4'b0100, 4'b0100, -1, -1);
    step(1, 4'b0100, 4'b0100, -1, -1);
    step(1, 4'b0100, 4'b0100, -1, -1);
    // ptr 3 -> grant 1 -> ptr 2
    step(1, 4'b0010, 4'b0010, -1, -1);
    repeat (3) step(1, 4'b0000, 4'b0000, -1, 1);
    step(1, 4'b0000, 4'b0000, 0, 1);
    // requesters 1 and 3 from ptr 2
    step(1, 4'b1010, 4'b1000, 0, 1);
    step(1, 4'b1010, 4'b0010, 1, -1);
    step(1, 4'b1010, 4'b1000, 2, -1);
    step(1, 4'b1010, 4'b0010, 3, -1);
    step(1, 4'b1010, 4'b1000, 3, -1);
    step(1, 4'b1010, 4'b0010, 3, -1);
    // enable falls with 3 in flight
    step(0, 4'b1010, 4'b1000, 3, 1);
    step(0, 4'b1010, 4'b0000, 3, 1);
    step(0, 4'b1010, 4'b0000, 2, 1);
    step(0, 4'b1010, 4'b0000, 1, 1);
    step(0, 4'b1010, 4'b0000, 0, 1);
    step(0, 4'b1010, 4'b0000, 0, 0);
    // re-enable during drain
    step(1, 4'b0000, 4'b0000, 0, 0);
    step(1, 4'b0001, 4'b0001, 0, 1);
    step(0, 4'b0011, 4'b0010, 1, 1);
    step(1, 4'b0011, 4'b0000, 2, 1);
    step(1, 4'b0011, 4'b0001, -1, 1);
    step(1, 4'b0011, 4'b0010, -1, 1);
    repeat (3) step(1, 4'b0000, 4'b0000, -1, 1);
    step(1, 4'b0000, 4'b0000, 0, 1);
    // reset with 2 in flight
    step(1, 4'b0101, 4'b0100, 0, 1);
    step(1, 4'b0101, 4'b0001, 1, 1);
    en = 1'b0;
    bus.i_req_valid = '0;
    @(negedge clk);
    chk("pre_reset_inflight", 32'(inflight), 2);
    #1 rst_n = 1'b0;
    exp_q.delete();
    #1 chk_zero("async_reset");
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    step(0, 4'b0000, 4'b0000, 0, 0);
    step(0, 4'b0000, 4'b0000, 0, 0);
    step(0, 4'b0000, 4'b0000, 0, 0);
    chk("sb_empty", 32'(exp_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
